// File: rtl/sd_data_rx_ctrl_pkg.sv
// Shared types and constants for the SD 4-bit data receive controller:
// FSM state encoding and the CCITT CRC16 used on every DAT line.
package sd_data_rx_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_SB = 3'd1,
        ST_DATA    = 3'd2,
        ST_CRC     = 3'd3,
        ST_END_BIT = 3'd4,
        ST_FIN     = 3'd5
    } rx_state_e;

    localparam int          CRC_LEN  = 16;
    localparam logic [15:0] CRC_POLY = 16'h1021;

    // One serial step of x^16+x^12+x^5+1, data bit entering at the MSB side.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
        logic fb;
        fb = crc[15] ^ bit_in;
        return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/sd_data_rx_ctrl_if.sv
// Control, DAT pad and RX FIFO signals of the data receive controller.
// The controller uses the slave view; whoever drives it uses master.
interface sd_data_rx_ctrl_if #(
    parameter int BLKSIZE_W = 12,
    parameter int BLKCNT_W  = 8,
    parameter int TMO_W     = 16
);
    logic                 start;
    logic                 abort;
    logic [BLKSIZE_W-1:0] blk_size;
    logic [BLKCNT_W-1:0]  blk_cnt;
    logic [TMO_W-1:0]     timeout_val;
    logic [3:0]           dat_i;
    logic                 fifo_full;
    logic                 fifo_wr;
    logic [3:0]           fifo_d;
    logic                 busy;
    logic                 done;
    logic                 crc_err;
    logic                 tmo_err;
    logic                 ovr_err;

    modport master (
        output start, abort, blk_size, blk_cnt, timeout_val, dat_i, fifo_full,
        input  fifo_wr, fifo_d, busy, done, crc_err, tmo_err, ovr_err
    );

    modport slave (
        input  start, abort, blk_size, blk_cnt, timeout_val, dat_i, fifo_full,
        output fifo_wr, fifo_d, busy, done, crc_err, tmo_err, ovr_err
    );
endinterface

// File: rtl/sd_data_rx_ctrl_crc16.sv
// Serial 1-bit CRC16 register with synchronous clear and enable; one per DAT line.
module sd_data_rx_ctrl_crc16
    import sd_data_rx_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic        bit_in,
    output logic [15:0] crc
);
    logic [15:0] crc_r;

    // CRC shift register: clear wins over a data step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_r <= 16'h0000;
        end else if (clr) begin
            crc_r <= 16'h0000;
        end else if (en) begin
            crc_r <= crc16_step(crc_r, bit_in);
        end else begin
            crc_r <= crc_r;
        end
    end

    assign crc = crc_r;
endmodule

// File: rtl/sd_data_rx_ctrl.sv
// SD 4-bit data receive controller: start-bit hunt, nibble deserialisation into the
// RX FIFO, per-line CRC16 and end-bit checking, all on the FIFO write clock.
module sd_data_rx_ctrl
    import sd_data_rx_ctrl_pkg::*;
#(
    parameter int BLKSIZE_W = 12,
    parameter int BLKCNT_W  = 8,
    parameter int TMO_W     = 16
) (
    input logic               clk,
    input logic               rst,
    sd_data_rx_ctrl_if.slave  bus
);
    localparam logic [BLKSIZE_W-1:0] BS_ZERO  = {BLKSIZE_W{1'b0}};
    localparam logic [BLKSIZE_W:0]   NIB_ONE  = {{BLKSIZE_W{1'b0}}, 1'b1};
    localparam logic [BLKCNT_W-1:0]  BC_ZERO  = {BLKCNT_W{1'b0}};
    localparam logic [BLKCNT_W-1:0]  BC_ONE   = {{(BLKCNT_W-1){1'b0}}, 1'b1};
    localparam logic [TMO_W-1:0]     TMO_ZERO = {TMO_W{1'b0}};
    localparam logic [TMO_W-1:0]     TMO_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};
    localparam logic [3:0]           CRC_LAST = 4'(CRC_LEN - 1);

    rx_state_e            state_r, state_nxt;
    logic [3:0]           dat_q_r;
    logic [BLKSIZE_W-1:0] blk_size_r, blk_size_nxt;
    logic [BLKCNT_W-1:0]  blk_left_r, blk_left_nxt;
    logic [BLKSIZE_W:0]   nib_cnt_r, nib_cnt_nxt;
    logic [TMO_W-1:0]     tmo_cnt_r, tmo_cnt_nxt;
    logic [3:0]           crc_idx_r, crc_idx_nxt;
    logic                 fifo_wr_r, fifo_wr_nxt;
    logic [3:0]           fifo_d_r, fifo_d_nxt;
    logic                 busy_r, busy_nxt;
    logic                 done_r, done_nxt;
    logic                 crc_err_r, crc_err_nxt;
    logic                 tmo_err_r, tmo_err_nxt;
    logic                 ovr_err_r, ovr_err_nxt;
    logic                 crc_clr_s, crc_en_s;
    logic [3:0]           crc_miss_s;
    logic [15:0]          crc_s [4];

    // Received CRC bits arrive MSB first, so bit index 15-crc_idx is ~crc_idx.
    for (genvar k = 0; k < 4; k++) begin : g_crc
        sd_data_rx_ctrl_crc16 u_crc (
            .clk    (clk),
            .rst    (rst),
            .clr    (crc_clr_s),
            .en     (crc_en_s),
            .bit_in (dat_q_r[k]),
            .crc    (crc_s[k])
        );
        assign crc_miss_s[k] = dat_q_r[k] ^ crc_s[k][~crc_idx_r];
    end

    // State, counters, pad sampling and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            dat_q_r    <= 4'hF;
            blk_size_r <= BS_ZERO;
            blk_left_r <= BC_ZERO;
            nib_cnt_r  <= {NIB_ONE[BLKSIZE_W:1], 1'b0};
            tmo_cnt_r  <= TMO_ZERO;
            crc_idx_r  <= 4'd0;
            fifo_wr_r  <= 1'b0;
            fifo_d_r   <= 4'h0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            crc_err_r  <= 1'b0;
            tmo_err_r  <= 1'b0;
            ovr_err_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt;
            dat_q_r    <= bus.dat_i;
            blk_size_r <= blk_size_nxt;
            blk_left_r <= blk_left_nxt;
            nib_cnt_r  <= nib_cnt_nxt;
            tmo_cnt_r  <= tmo_cnt_nxt;
            crc_idx_r  <= crc_idx_nxt;
            fifo_wr_r  <= fifo_wr_nxt;
            fifo_d_r   <= fifo_d_nxt;
            busy_r     <= busy_nxt;
            done_r     <= done_nxt;
            crc_err_r  <= crc_err_nxt;
            tmo_err_r  <= tmo_err_nxt;
            ovr_err_r  <= ovr_err_nxt;
        end
    end

    // Next-state and datapath control; abort overrides everything, including start.
    always_comb begin
        state_nxt    = state_r;
        blk_size_nxt = blk_size_r;
        blk_left_nxt = blk_left_r;
        nib_cnt_nxt  = nib_cnt_r;
        tmo_cnt_nxt  = tmo_cnt_r;
        crc_idx_nxt  = crc_idx_r;
        fifo_wr_nxt  = 1'b0;
        fifo_d_nxt   = fifo_d_r;
        busy_nxt     = busy_r & ~done_r;
        done_nxt     = 1'b0;
        crc_err_nxt  = crc_err_r;
        tmo_err_nxt  = tmo_err_r;
        ovr_err_nxt  = ovr_err_r;
        crc_clr_s    = 1'b0;
        crc_en_s     = 1'b0;
        if (bus.abort) begin
            state_nxt = ST_IDLE;
            busy_nxt  = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // busy_r is still high during the done cycle, so start is ignored there
                    if (bus.start && !busy_r) begin
                        blk_size_nxt = bus.blk_size;
                        blk_left_nxt = bus.blk_cnt;
                        tmo_cnt_nxt  = TMO_ZERO;
                        busy_nxt     = 1'b1;
                        crc_err_nxt  = 1'b0;
                        tmo_err_nxt  = 1'b0;
                        ovr_err_nxt  = 1'b0;
                        if (bus.blk_size == BS_ZERO || bus.blk_cnt == BC_ZERO) begin
                            state_nxt = ST_FIN;
                        end else begin
                            state_nxt = ST_WAIT_SB;
                        end
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
                ST_WAIT_SB: begin
                    if (dat_q_r == 4'h0) begin
                        state_nxt   = ST_DATA;
                        nib_cnt_nxt = {blk_size_r, 1'b0};
                        crc_clr_s   = 1'b1;
                    end else if (bus.timeout_val != TMO_ZERO &&
                                 tmo_cnt_r + TMO_ONE == bus.timeout_val) begin
                        tmo_err_nxt = 1'b1;
                        state_nxt   = ST_FIN;
                    end else begin
                        tmo_cnt_nxt = tmo_cnt_r + TMO_ONE;
                    end
                end
                ST_DATA: begin
                    crc_en_s   = 1'b1;
                    fifo_d_nxt = dat_q_r;
                    if (bus.fifo_full) begin
                        ovr_err_nxt = 1'b1;
                    end else begin
                        fifo_wr_nxt = 1'b1;
                    end
                    if (nib_cnt_r == NIB_ONE) begin
                        state_nxt   = ST_CRC;
                        crc_idx_nxt = 4'd0;
                    end else begin
                        nib_cnt_nxt = nib_cnt_r - NIB_ONE;
                    end
                end
                ST_CRC: begin
                    crc_err_nxt = crc_err_r | (|crc_miss_s);
                    if (crc_idx_r == CRC_LAST) begin
                        state_nxt = ST_END_BIT;
                    end else begin
                        crc_idx_nxt = crc_idx_r + 4'd1;
                    end
                end
                ST_END_BIT: begin
                    crc_err_nxt  = crc_err_r | (dat_q_r != 4'hF);
                    blk_left_nxt = blk_left_r - BC_ONE;
                    tmo_cnt_nxt  = TMO_ZERO;
                    if (blk_left_r == BC_ONE) begin
                        state_nxt = ST_FIN;
                    end else begin
                        state_nxt = ST_WAIT_SB;
                    end
                end
                ST_FIN: begin
                    done_nxt  = 1'b1;
                    state_nxt = ST_IDLE;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.fifo_wr = fifo_wr_r;
    assign bus.fifo_d  = fifo_d_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.crc_err = crc_err_r;
    assign bus.tmo_err = tmo_err_r;
    assign bus.ovr_err = ovr_err_r;
endmodule

// File: tb/tb_sd_data_rx_ctrl.sv
// Randomised self-checking bench for sd_data_rx_ctrl; expected CRCs come from plain
// polynomial long division of each DAT line's bit stream.
module tb_sd_data_rx_ctrl;
    localparam int BLKSIZE_W = 12;
    localparam int BLKCNT_W  = 8;
    localparam int TMO_W     = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    sd_data_rx_ctrl_if #(.BLKSIZE_W(BLKSIZE_W), .BLKCNT_W(BLKCNT_W), .TMO_W(TMO_W)) bus ();

    sd_data_rx_ctrl #(.BLKSIZE_W(BLKSIZE_W), .BLKCNT_W(BLKCNT_W), .TMO_W(TMO_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int         cyc = 0;
    logic [3:0] got_q [$];
    int         done_cnt = 0;
    int         done_cyc = 0;
    logic       prev_done = 1'b0;
    logic       busy_after_done = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe the FIFO port and done/busy timing away from the active edge.
    always @(negedge clk) begin
        if (bus.fifo_wr === 1'b1) got_q.push_back(bus.fifo_d);
        if (prev_done) busy_after_done = bus.busy;
        if (bus.done === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        prev_done = (bus.done === 1'b1);
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // CRC as remainder of M(x)*x^16 divided by G(x)=0x11021, computed by long division.
    function automatic logic [15:0] ref_crc(input logic [3:0] nibs [$], input int line);
        logic [16:0] rem;
        int          n;
        rem = 17'h0;
        n   = nibs.size();
        for (int i = 0; i < n + 16; i++) begin
            rem = {rem[15:0], (i < n) ? nibs[i][line] : 1'b0};
            if (rem[16]) rem = rem ^ 17'h11021;
        end
        return rem[15:0];
    endfunction

    task automatic drive(input logic [3:0] d, input logic full);
        @(posedge clk);
        #1;
        bus.dat_i     = d;
        bus.fifo_full = full;
    endtask

    task automatic start_xfer(input int bs, input int bc, input int tmo);
        @(posedge clk);
        #1;
        bus.blk_size    = BLKSIZE_W'(bs);
        bus.blk_cnt     = BLKCNT_W'(bc);
        bus.timeout_val = TMO_W'(tmo);
        bus.start       = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // fifo_full for nibble j is presented while nibble j sits in the DUT's input register.
    task automatic send_block(input logic [3:0] nibs [$], input int gap, input int flip_line,
                              input int flip_bit, input logic [3:0] end_nib,
                              input int full_lo, input int full_hi);
        logic [15:0] c [4];
        logic [3:0]  v;
        logic        prev_full;
        for (int k = 0; k < 4; k++) c[k] = ref_crc(nibs, k);
        if (flip_line >= 0) c[flip_line][flip_bit] = ~c[flip_line][flip_bit];
        repeat (gap) drive(4'hF, 1'b0);
        drive(4'h0, 1'b0);
        prev_full = 1'b0;
        for (int j = 0; j < nibs.size(); j++) begin
            drive(nibs[j], prev_full);
            prev_full = (j + 1 >= full_lo) && (j + 1 <= full_hi);
        end
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < 4; k++) v[k] = c[k][15 - i];
            drive(v, prev_full);
            prev_full = 1'b0;
        end
        drive(end_nib, 1'b0);
        drive(4'hF, 1'b0);
    endtask

    task automatic wait_done(input int base, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk);
            if (done_cnt > base) ok = 1'b1;
        end
    endtask

    // Full transfer; faults (CRC flip, bad end bit, FIFO full window) apply to block 0.
    task automatic run_xfer(input int bs, input int bc, input bit counting, input int flip_line,
                            input int flip_bit, input logic [3:0] end_nib, input int full_lo,
                            input int full_hi, output int nwr, output int nbad,
                            output int ndone, output bit ok);
        logic [3:0] nibs [$];
        logic [3:0] exp_q [$];
        int         base_w, base_d, gap;
        base_w = got_q.size();
        base_d = done_cnt;
        start_xfer(bs, bc, 0);
        for (int b = 0; b < bc; b++) begin
            nibs.delete();
            for (int j = 0; j < 2 * bs; j++) nibs.push_back(counting ? 4'(j + 1) : 4'($urandom));
            for (int j = 0; j < 2 * bs; j++)
                if (!(b == 0 && j + 1 >= full_lo && j + 1 <= full_hi)) exp_q.push_back(nibs[j]);
            gap = (b == 0) ? 3 : ((b % 2 == 1) ? 5 : 50);
            send_block(nibs, gap, (b == 0) ? flip_line : -1, flip_bit,
                       (b == 0) ? end_nib : 4'hF, (b == 0) ? full_lo : 0, (b == 0) ? full_hi : 0);
        end
        wait_done(base_d, 200, ok);
        repeat (3) @(posedge clk);
        nwr  = got_q.size() - base_w;
        nbad = 0;
        for (int j = 0; j < exp_q.size(); j++)
            if (base_w + j >= got_q.size() || got_q[base_w + j] !== exp_q[j]) nbad++;
        ndone = done_cnt - base_d;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.fifo_wr, bus.fifo_d, bus.busy, bus.done, bus.crc_err, bus.tmo_err, bus.ovr_err} !== 10'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0", {bus.fifo_wr, bus.fifo_d, bus.busy,
                     bus.done, bus.crc_err, bus.tmo_err, bus.ovr_err});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b done=%b expected 0/0", bus.busy, bus.done);
        end
    endtask

    task automatic test_basic();
        int nwr, nbad, ndone;
        bit ok;
        run_xfer(4, 1, 1'b1, -1, 0, 4'hF, 0, 0, nwr, nbad, ndone, ok);
        checks++;
        if (!ok || ndone !== 1) begin errors++; $display("FAIL basic_done: ok=%0d count=%0d expected 1", ok, ndone); end
        checks++;
        if (nwr !== 8 || nbad !== 0) begin errors++; $display("FAIL basic_writes: writes=%0d bad=%0d expected 8/0", nwr, nbad); end
        checks++;
        if ({bus.crc_err, bus.tmo_err, bus.ovr_err} !== 3'b000) begin
            errors++; $display("FAIL basic_errors: got %b expected 000", {bus.crc_err, bus.tmo_err, bus.ovr_err});
        end
        checks++;
        if (busy_after_done !== 1'b0) begin errors++; $display("FAIL basic_busy_drop: busy=%b expected 0", busy_after_done); end
    endtask

    task automatic test_random();
        int nwr, nbad, ndone, bs, bc;
        bit ok;
        for (int r = 0; r < 3; r++) begin
            bs = $urandom_range(1, 20);
            bc = $urandom_range(1, 3);
            run_xfer(bs, bc, 1'b0, -1, 0, 4'hF, 0, 0, nwr, nbad, ndone, ok);
            checks++;
            if (!ok || ndone !== 1 || nwr !== 2 * bs * bc || nbad !== 0 ||
                {bus.crc_err, bus.tmo_err, bus.ovr_err} !== 3'b000) begin
                errors++;
                $display("FAIL random_xfer bs=%0d bc=%0d: done=%0d writes=%0d bad=%0d errs=%b expected 1/%0d/0/000",
                         bs, bc, ndone, nwr, nbad, {bus.crc_err, bus.tmo_err, bus.ovr_err}, 2 * bs * bc);
            end
        end
    endtask

    task automatic test_back_to_back();
        int nwr, nbad, ndone;
        bit ok;
        run_xfer(512, 3, 1'b0, -1, 0, 4'hF, 0, 0, nwr, nbad, ndone, ok);
        checks++;
        if (nwr !== 3072 || nbad !== 0) begin errors++; $display("FAIL b2b_writes: writes=%0d bad=%0d expected 3072/0", nwr, nbad); end
        checks++;
        if (!ok || ndone !== 1) begin errors++; $display("FAIL b2b_done: count=%0d expected 1", ndone); end
        checks++;
        if (busy_after_done !== 1'b0 || {bus.crc_err, bus.tmo_err, bus.ovr_err} !== 3'b000) begin
            errors++; $display("FAIL b2b_status: busy=%b errs=%b expected 0/000", busy_after_done,
                               {bus.crc_err, bus.tmo_err, bus.ovr_err});
        end
    endtask

    task automatic test_crc_err();
        int nwr, nbad, ndone, fb;
        bit ok;
        fb = $urandom_range(0, 15);
        run_xfer(4, 1, 1'b1, 2, fb, 4'hF, 0, 0, nwr, nbad, ndone, ok);
        checks++;
        if (bus.crc_err !== 1'b1 || nwr !== 8 || nbad !== 0 || ndone !== 1) begin
            errors++; $display("FAIL crc_flip bit=%0d: crc_err=%b writes=%0d bad=%0d done=%0d expected 1/8/0/1",
                               fb, bus.crc_err, nwr, nbad, ndone);
        end
        run_xfer(4, 1, 1'b1, -1, 0, 4'hE, 0, 0, nwr, nbad, ndone, ok);
        checks++;
        if (bus.crc_err !== 1'b1 || ndone !== 1) begin
            errors++; $display("FAIL bad_end_bit: crc_err=%b done=%0d expected 1/1", bus.crc_err, ndone);
        end
    endtask

    task automatic test_zero_size();
        int sc, base_d, base_w;
        base_d = done_cnt;
        base_w = got_q.size();
        start_xfer(0, 1, 0);
        sc = cyc;
        repeat (4) @(posedge clk);
        checks++;
        if (done_cnt - base_d !== 1 || done_cyc - sc !== 1 || got_q.size() !== base_w ||
            {bus.crc_err, bus.tmo_err, bus.ovr_err} !== 3'b000) begin
            errors++; $display("FAIL zero_blk_size: done=%0d at +%0d writes=%0d expected 1 at +1, 0 writes",
                               done_cnt - base_d, done_cyc - sc, got_q.size() - base_w);
        end
        base_d = done_cnt;
        start_xfer(3, 0, 0);
        repeat (4) @(posedge clk);
        checks++;
        if (done_cnt - base_d !== 1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL zero_blk_cnt: done=%0d busy=%b expected 1/0", done_cnt - base_d, bus.busy);
        end
    endtask

    task automatic test_timeout();
        int  sc, base_d, base_w;
        bit  ok;
        base_d = done_cnt;
        base_w = got_q.size();
        start_xfer(4, 1, 100);
        sc = cyc;
        wait_done(base_d, 300, ok);
        repeat (3) @(posedge clk);
        checks++;
        if (!ok || done_cyc - sc !== 101) begin
            errors++; $display("FAIL tmo_latency: ok=%0d done at +%0d expected +101", ok, done_cyc - sc);
        end
        checks++;
        if (bus.tmo_err !== 1'b1 || bus.crc_err !== 1'b0 || got_q.size() !== base_w || busy_after_done !== 1'b0) begin
            errors++; $display("FAIL tmo_status: tmo_err=%b crc_err=%b writes=%0d busy=%b expected 1/0/0/0",
                               bus.tmo_err, bus.crc_err, got_q.size() - base_w, busy_after_done);
        end
        base_d = done_cnt;
        start_xfer(4, 1, 0);
        repeat (150) @(posedge clk);
        start_xfer(0, 1, 0);
        repeat (150) @(posedge clk);
        #1;
        checks++;
        if (done_cnt !== base_d || bus.busy !== 1'b1 || bus.tmo_err !== 1'b0) begin
            errors++; $display("FAIL tmo_infinite: done=%0d busy=%b tmo_err=%b expected 0/1/0",
                               done_cnt - base_d, bus.busy, bus.tmo_err);
        end
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        repeat (3) @(posedge clk);
        checks++;
        if (bus.busy !== 1'b0 || done_cnt !== base_d) begin
            errors++; $display("FAIL tmo_abort: busy=%b done=%0d expected 0/0", bus.busy, done_cnt - base_d);
        end
    endtask

    task automatic test_overrun();
        int nwr, nbad, ndone;
        bit ok;
        run_xfer(4, 1, 1'b1, -1, 0, 4'hF, 3, 4, nwr, nbad, ndone, ok);
        checks++;
        if (nwr !== 6 || nbad !== 0) begin errors++; $display("FAIL ovr_writes: writes=%0d bad=%0d expected 6/0", nwr, nbad); end
        checks++;
        if (bus.ovr_err !== 1'b1 || bus.crc_err !== 1'b0 || ndone !== 1) begin
            errors++; $display("FAIL ovr_flags: ovr=%b crc=%b done=%0d expected 1/0/1", bus.ovr_err, bus.crc_err, ndone);
        end
    endtask

    task automatic test_abort();
        int   base_d, nw, nwr, nbad, ndone;
        bit   ok;
        logic prev_full;
        base_d = done_cnt;
        start_xfer(512, 1, 0);
        drive(4'hF, 1'b0);
        drive(4'h0, 1'b0);
        prev_full = 1'b0;
        for (int j = 0; j < 200; j++) begin
            drive(4'($urandom), prev_full);
            prev_full = (j + 1 == 5);
        end
        @(posedge clk);
        #1;
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        nw = got_q.size();
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.fifo_wr !== 1'b0) begin
            errors++; $display("FAIL abort_next_cycle: busy=%b fifo_wr=%b expected 0/0", bus.busy, bus.fifo_wr);
        end
        for (int j = 0; j < 40; j++) drive(4'($urandom), 1'b0);
        drive(4'hF, 1'b0);
        repeat (3) @(posedge clk);
        checks++;
        if (got_q.size() !== nw || done_cnt !== base_d || bus.ovr_err !== 1'b1) begin
            errors++; $display("FAIL abort_quiet: extra_writes=%0d done=%0d ovr=%b expected 0/0/1",
                               got_q.size() - nw, done_cnt - base_d, bus.ovr_err);
        end
        run_xfer(4, 1, 1'b1, -1, 0, 4'hF, 0, 0, nwr, nbad, ndone, ok);
        checks++;
        if (nwr !== 8 || nbad !== 0 || ndone !== 1 || {bus.crc_err, bus.tmo_err, bus.ovr_err} !== 3'b000) begin
            errors++; $display("FAIL abort_restart: writes=%0d bad=%0d done=%0d errs=%b expected 8/0/1/000",
                               nwr, nbad, ndone, {bus.crc_err, bus.tmo_err, bus.ovr_err});
        end
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.blk_size    = '0;
        bus.blk_cnt     = '0;
        bus.timeout_val = '0;
        bus.dat_i       = 4'hF;
        bus.fifo_full   = 1'b0;
        test_reset();
        test_basic();
        test_random();
        test_back_to_back();
        test_crc_err();
        test_zero_size();
        test_timeout();
        test_overrun();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
